mdio_phy_slave: RTL

- PHY-side MDIO management slave and the downstream consumer of the MDIO master's MDC/MDIO_OUT/MDIO_OE outputs.
- Deserialises 32-bit Clause-22 frames: ST(2) OP(2) PHYAD(5) REGAD(5) TA(2) DATA(16), MSB first.
- Writes go into an internal 32x16 register bank. Reads drive 16 bits back on MDIO_IN.
- Runs on the same system clock as the master; MDC is treated as a sampled data input, not as a clock.

---
 rtl/mdio_phy_slave.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mdio_phy_slave.sv
// Clause-22 MDIO PHY-side slave: MDC is oversampled on clk, frames are shifted
// in on MDC rises, read data is driven on MDC falls from a 32x16 register bank.
//
// state   | meaning
// S_IDLE  | waiting for first frame bit with master driving
// S_HDR   | collecting ST/OP/PHYAD/REGAD (bits 2..14)
// S_TA    | turnaround bits 15..16
// S_WDATA | shifting in 16 write data bits
// S_RDATA | driving 16 read data bits, then releasing the line
module mdio_phy_slave #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0CC2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  output logic        MDIO_IN,
  output logic        MDIO_IN_EN,
  output logic        WR_STB,
  output logic [4:0]  REG_ADDR,
  output logic [15:0] WR_DATA,
  output logic        FRAME_ERR,
  output logic        BUSY
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_TA, S_WDATA, S_RDATA} state_t;

  state_t      state_q;
  logic        mdc_q;
  logic [5:0]  cnt_q;
  logic [14:0] sr_q;
  logic        match_q;
  logic        rd_op_q;
  logic [15:0] rd_sr_q;
  logic [15:0] bank_q [32];
  logic        mdio_in_q;
  logic        mdio_in_en_q;
  logic        wr_stb_q;
  logic [4:0]  reg_addr_q;
  logic [15:0] wr_data_q;
  logic        frame_err_q;

  logic        rise;
  logic        fall;
  logic [15:0] sr_d;
  logic [1:0]  hdr_st;
  logic [1:0]  hdr_op;
  logic [4:0]  hdr_phyad;
  logic [4:0]  hdr_regad;
  logic        hdr_ok;
  logic        wr_allowed;
  logic [15:0] rd_val;

  assign rise      = MDC & ~mdc_q;
  assign fall      = ~MDC & mdc_q;
  assign sr_d      = {sr_q, MDIO_OUT};
  // Header fields as they stand once bit 14 is shifted in
  assign hdr_st    = sr_d[13:12];
  assign hdr_op    = sr_d[11:10];
  assign hdr_phyad = sr_d[9:5];
  assign hdr_regad = sr_d[4:0];
  assign hdr_ok    = (hdr_st == 2'b01) && ((hdr_op == 2'b01) || (hdr_op == 2'b10));
  assign wr_allowed = match_q && (reg_addr_q != 5'd2) && (reg_addr_q != 5'd3);

  always_comb begin
    rd_val = bank_q[reg_addr_q];
    if (reg_addr_q == 5'd2) rd_val = PHY_ID1;
    else if (reg_addr_q == 5'd3) rd_val = PHY_ID2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mdc_q        <= 1'b0;
      cnt_q        <= '0;
      sr_q         <= '0;
      match_q      <= 1'b0;
      rd_op_q      <= 1'b0;
      rd_sr_q      <= '0;
      mdio_in_q    <= 1'b0;
      mdio_in_en_q <= 1'b0;
      wr_stb_q     <= 1'b0;
      reg_addr_q   <= '0;
      wr_data_q    <= '0;
      frame_err_q  <= 1'b0;
      for (int i = 0; i < 32; i++) bank_q[i] <= '0;
    end else begin
      mdc_q       <= MDC;
      wr_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rise && MDIO_OE) begin
            sr_q    <= {14'b0, MDIO_OUT};
            cnt_q   <= 6'd1;
            state_q <= S_HDR;
          end
        end
        S_HDR: begin
          if (rise) begin
            if (!MDIO_OE) begin
              frame_err_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= S_IDLE;
            end else begin
              sr_q  <= sr_d[14:0];
              cnt_q <= cnt_q + 6'd1;
              if (cnt_q == 6'd13) begin
                if (!hdr_ok) begin
                  frame_err_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= S_IDLE;
                end else begin
                  reg_addr_q <= hdr_regad;
                  match_q    <= (hdr_phyad == PHY_ADDR);
                  rd_op_q    <= (hdr_op == 2'b10);
                  state_q    <= S_TA;
                end
              end
            end
          end
        end
        S_TA: begin
          if (rise) begin
            // Master releases the line during a read turnaround, so OE only matters for writes
            if (!rd_op_q && !MDIO_OE) begin
              frame_err_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= S_IDLE;
            end else begin
              sr_q  <= sr_d[14:0];
              cnt_q <= cnt_q + 6'd1;
              if (cnt_q == 6'd15) begin
                if (rd_op_q) begin
                  rd_sr_q <= rd_val;
                  state_q <= S_RDATA;
                end else if (sr_d[1:0] != 2'b10) begin
                  frame_err_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= S_IDLE;
                end else begin
                  state_q <= S_WDATA;
                end
              end
            end
          end
        end
        S_WDATA: begin
          if (rise) begin
            if (!MDIO_OE) begin
              frame_err_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= S_IDLE;
            end else begin
              sr_q  <= sr_d[14:0];
              cnt_q <= cnt_q + 6'd1;
              if (cnt_q == 6'd31) begin
                if (wr_allowed) begin
                  bank_q[reg_addr_q] <= sr_d;
                  wr_data_q          <= sr_d;
                  wr_stb_q           <= 1'b1;
                end
                cnt_q   <= '0;
                state_q <= S_IDLE;
              end
            end
          end
        end
        S_RDATA: begin
          if (rise && (cnt_q != 6'd32)) begin
            cnt_q <= cnt_q + 6'd1;
          end else if (fall) begin
            if (cnt_q == 6'd32) begin
              mdio_in_en_q <= 1'b0;
              mdio_in_q    <= 1'b0;
              cnt_q        <= '0;
              state_q      <= S_IDLE;
            end else if (match_q) begin
              mdio_in_en_q <= 1'b1;
              mdio_in_q    <= rd_sr_q[15];
              rd_sr_q      <= {rd_sr_q[14:0], 1'b0};
            end
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign MDIO_IN    = mdio_in_q;
  assign MDIO_IN_EN = mdio_in_en_q;
  assign WR_STB     = wr_stb_q;
  assign REG_ADDR   = reg_addr_q;
  assign WR_DATA    = wr_data_q;
  assign FRAME_ERR  = frame_err_q;
  assign BUSY       = (state_q != S_IDLE);

endmodule
